fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 25 ++
 rtl/fetch_sequencer_starve_counter.sv | 41 ++++
 rtl/fetch_sequencer.sv | 138 +++++++++++++
 tb/tb_fetch_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding and
// default widths.
package fetch_sequencer_pkg;

  localparam int BITS_DATA_DEF  = 32;
  localparam int BITS_ADDR_DEF  = 5;
  localparam int STARVE_MAX_DEF = 4;

  // Fetch sequencer states
  //   state   | meaning
  //   ST_BOOT | one cycle after reset, PC forced to 0, decode untouched
  //   ST_RUN  | normal fetch, PCF = PC
  //   ST_DBG  | one-cycle debug ROM read, PCF = dbg_addr, PC held
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DBG  = 2'd2
  } fetch_state_e;

  // Counter width able to hold 0..max_cnt (at least one bit).
  function automatic int starve_width(input int max_cnt);
    return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_starve_counter.sv
// Saturating wait counter: how long a debug request has been denied while
// fetch keeps running. Saturation forces the next grant.
module fetch_sequencer_starve_counter
  import fetch_sequencer_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic sat_o
);

  localparam int W = starve_width(STARVE_MAX);
  localparam logic [W-1:0] CNT_MAX = W'(STARVE_MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; increment stops at CNT_MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the external ROM address, registers the
// decode-stage instruction, and steals single ROM cycles for debug reads.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int BITS_DATA  = BITS_DATA_DEF,
  parameter int BITS_ADDR  = BITS_ADDR_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 StallF,
  input  logic                 FlushD,
  input  logic                 BranchE,
  input  logic [BITS_ADDR-1:0] PCBranchE,
  input  logic                 dbg_req,
  input  logic [BITS_ADDR-1:0] dbg_addr,
  output logic                 dbg_ack,
  output logic [BITS_DATA-1:0] dbg_data,
  output logic [BITS_ADDR-1:0] PCF,
  input  logic [BITS_DATA-1:0] InstrF,
  output logic [BITS_DATA-1:0] InstrD,
  output logic                 ValidD,
  output logic [BITS_ADDR-1:0] PCD
);

  fetch_state_e         state_q, state_d;
  logic [BITS_ADDR-1:0] pc_q, pc_d;
  logic [BITS_ADDR-1:0] pcd_q, pcd_d;
  logic [BITS_DATA-1:0] instr_q, instr_d;
  logic [BITS_DATA-1:0] dbg_data_q, dbg_data_d;
  logic                 valid_q, valid_d;
  logic                 ack_q, ack_d;
  logic                 grant;
  logic                 starve_sat;
  logic                 starve_inc;
  logic                 starve_clr;

  // A grant needs RUN, a live request, not the ack cycle of the previous read,
  // and either a stalled fetch (free ROM cycle) or an exhausted wait budget.
  assign grant      = (state_q == ST_RUN) && dbg_req && !ack_q && (StallF || starve_sat);
  assign starve_inc = (state_q == ST_RUN) && dbg_req && !grant;
  // Dropping the request also clears, so a new request gets the full budget.
  assign starve_clr = grant || !dbg_req;

  fetch_sequencer_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (starve_clr),
    .inc_i (starve_inc),
    .sat_o (starve_sat)
  );

  // ROM address mux: debug address only during the stolen cycle.
  always_comb begin
    unique case (state_q)
      ST_RUN:  PCF = pc_q;
      ST_DBG:  PCF = dbg_addr;
      default: PCF = '0;
    endcase
  end

  // Next-state for FSM and fetch/decode registers; a branch overrides PC and
  // kills the decode slot in every state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pcd_d      = pcd_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    dbg_data_d = dbg_data_q;
    ack_d      = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        pc_d    = '0;
      end
      ST_RUN: begin
        if (grant) begin
          state_d = ST_DBG;
        end
        if (!StallF) begin
          pc_d    = pc_q + BITS_ADDR'(1);
          instr_d = InstrF;
          pcd_d   = pc_q;
          valid_d = !FlushD;
        end else if (FlushD) begin
          valid_d = 1'b0;
        end
      end
      ST_DBG: begin
        state_d    = ST_RUN;
        dbg_data_d = InstrF;
        ack_d      = 1'b1;
        if (!StallF || FlushD) begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
    if (BranchE) begin
      pc_d    = PCBranchE;
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= '0;
      pcd_q      <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      dbg_data_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pcd_q      <= pcd_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      dbg_data_q <= dbg_data_d;
      ack_q      <= ack_d;
    end
  end

  assign InstrD   = instr_q;
  assign ValidD   = valid_q;
  assign PCD      = pcd_q;
  assign dbg_ack  = ack_q;
  assign dbg_data = dbg_data_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer with a behavioural ROM holding ROM[i] = i + 0x100.
module tb_fetch_sequencer;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          StallF;
  logic          FlushD;
  logic          BranchE;
  logic [AW-1:0] PCBranchE;
  logic          dbg_req;
  logic [AW-1:0] dbg_addr;
  logic          dbg_ack;
  logic [DW-1:0] dbg_data;
  logic [AW-1:0] PCF;
  logic [DW-1:0] InstrF;
  logic [DW-1:0] InstrD;
  logic          ValidD;
  logic [AW-1:0] PCD;

  logic [DW-1:0] rom [0:(1<<AW)-1];

  fetch_sequencer #(
    .BITS_DATA  (DW),
    .BITS_ADDR  (AW),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StallF    (StallF),
    .FlushD    (FlushD),
    .BranchE   (BranchE),
    .PCBranchE (PCBranchE),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_ack   (dbg_ack),
    .dbg_data  (dbg_data),
    .PCF       (PCF),
    .InstrF    (InstrF),
    .InstrD    (InstrD),
    .ValidD    (ValidD),
    .PCD       (PCD)
  );

  assign InstrF = rom[PCF];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          stall;
    logic          flush;
    logic          br;
    logic [AW-1:0] pcb;
    logic          dreq;
    logic [AW-1:0] daddr;
    logic [AW-1:0] e_pcf;
    logic          e_valid;
    logic          chk_id;
    logic [DW-1:0] e_instr;
    logic [AW-1:0] e_pcd;
    logic          e_ack;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl[$];
  vec_t tbl2[$];
  vec_t sb_q[$];
  int   n_vec;
  int   n_err;

  function automatic vec_t mk(input int stall, input int flush, input int br, input int pcb,
                              input int dreq, input int daddr, input int e_pcf, input int e_valid,
                              input int chk_id, input int e_instr, input int e_pcd,
                              input int e_ack, input int e_data);
    vec_t v;
    v.stall   = 1'(stall);
    v.flush   = 1'(flush);
    v.br      = 1'(br);
    v.pcb     = AW'(pcb);
    v.dreq    = 1'(dreq);
    v.daddr   = AW'(daddr);
    v.e_pcf   = AW'(e_pcf);
    v.e_valid = 1'(e_valid);
    v.chk_id  = 1'(chk_id);
    v.e_instr = DW'(e_instr);
    v.e_pcd   = AW'(e_pcd);
    v.e_ack   = 1'(e_ack);
    v.e_data  = DW'(e_data);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check the combinational ROM
  // address, then check the registered outputs just after the rising edge.
  task automatic step(input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    StallF    = v.stall;
    FlushD    = v.flush;
    BranchE   = v.br;
    PCBranchE = v.pcb;
    dbg_req   = v.dreq;
    dbg_addr  = v.daddr;
    sb_q.push_back(v);
    #1;
    chk($sformatf("v%0d PCF", idx), 32'(PCF), 32'(v.e_pcf));
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk($sformatf("v%0d ValidD", idx), 32'(ValidD), 32'(e.e_valid));
    if (e.chk_id) begin
      chk($sformatf("v%0d InstrD", idx), InstrD, e.e_instr);
      chk($sformatf("v%0d PCD", idx), 32'(PCD), 32'(e.e_pcd));
    end
    chk($sformatf("v%0d dbg_ack", idx), 32'(dbg_ack), 32'(e.e_ack));
    chk($sformatf("v%0d dbg_data", idx), dbg_data, e.e_data);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " PCF"}, 32'(PCF), 32'd0);
    chk({tag, " ValidD"}, 32'(ValidD), 32'd0);
    chk({tag, " InstrD"}, InstrD, 32'd0);
    chk({tag, " PCD"}, 32'(PCD), 32'd0);
    chk({tag, " dbg_ack"}, 32'(dbg_ack), 32'd0);
    chk({tag, " dbg_data"}, dbg_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < (1 << AW); i++) rom[i] = DW'(32'h100 + i);

    //                  st fl br pcb rq ad  pcf v  id instr    pcd ack data
    // boot then free-running fetch from 0
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,  0,  0, 1, 0,       0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,  0,  1, 1, 'h100,   0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,  1,  1, 1, 'h101,   1,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,  2,  1, 1, 'h102,   2,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,  3,  1, 1, 'h103,   3,  0, 0));
    // branch to 30, then wrap 31 -> 0
    tbl.push_back(mk(0, 0, 1, 30, 0, 0,  4,  0, 0, 0,       0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,  30, 1, 1, 'h11E,   30, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,  31, 1, 1, 'h11F,   31, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,  0,  1, 1, 'h100,   0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,  1,  1, 1, 'h101,   1,  0, 0));
    // two stalled cycles, branch to 7 in the second
    tbl.push_back(mk(1, 0, 0, 0,  0, 0,  2,  1, 1, 'h101,   1,  0, 0));
    tbl.push_back(mk(1, 0, 1, 7,  0, 0,  2,  0, 0, 0,       0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,  7,  1, 1, 'h107,   7,  0, 0));
    // flush without stall advances PC, flush with stall holds it
    tbl.push_back(mk(0, 1, 0, 0,  0, 0,  8,  0, 0, 0,       0,  0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  0, 0,  9,  0, 0, 0,       0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,  9,  1, 1, 'h109,   9,  0, 0));
    // debug read of 20 during a stall; request still up in the ack cycle
    tbl.push_back(mk(1, 0, 0, 0,  1, 20, 10, 1, 1, 'h109,   9,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  1, 20, 20, 1, 1, 'h109,   9,  1, 'h114));
    tbl.push_back(mk(1, 0, 0, 0,  1, 20, 10, 1, 1, 'h109,   9,  0, 'h114));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,  10, 1, 1, 'h10A,   10, 0, 'h114));
    // debug read of 9 with fetch never stalled: forced grant after 4 waits
    tbl.push_back(mk(0, 0, 0, 0,  1, 9,  11, 1, 1, 'h10B,   11, 0, 'h114));
    tbl.push_back(mk(0, 0, 0, 0,  1, 9,  12, 1, 1, 'h10C,   12, 0, 'h114));
    tbl.push_back(mk(0, 0, 0, 0,  1, 9,  13, 1, 1, 'h10D,   13, 0, 'h114));
    tbl.push_back(mk(0, 0, 0, 0,  1, 9,  14, 1, 1, 'h10E,   14, 0, 'h114));
    tbl.push_back(mk(0, 0, 0, 0,  1, 9,  15, 1, 1, 'h10F,   15, 0, 'h114));
    tbl.push_back(mk(0, 0, 0, 0,  1, 9,  9,  0, 1, 'h10F,   15, 1, 'h109));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,  16, 1, 1, 'h110,   16, 0, 'h109));
    // enter DBG for address 5 (aborted by reset below)
    tbl.push_back(mk(1, 0, 0, 0,  1, 5,  17, 1, 1, 'h110,   16, 0, 'h109));

    // after reset mid-DBG: boot, then fetch from 0
    tbl2.push_back(mk(0, 0, 0, 0, 0, 0,  0,  0, 1, 0,       0,  0, 0));
    tbl2.push_back(mk(0, 0, 0, 0, 0, 0,  0,  1, 1, 'h100,   0,  0, 0));
    tbl2.push_back(mk(0, 0, 0, 0, 0, 0,  1,  1, 1, 'h101,   1,  0, 0));

    rst_n     = 1'b0;
    StallF    = 1'b0;
    FlushD    = 1'b0;
    BranchE   = 1'b0;
    PCBranchE = '0;
    dbg_req   = 1'b0;
    dbg_addr  = '0;
    #2;
    check_reset_vals("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(i + 1, tbl[i]);

    // Reset asserted in the middle of the debug cycle.
    @(negedge clk);
    StallF   = 1'b1;
    dbg_req  = 1'b1;
    dbg_addr = 5'd5;
    #1;
    chk("dbg5 PCF", 32'(PCF), 32'd5);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_in_dbg");
    @(posedge clk);
    #1;
    chk("rst_in_dbg edge dbg_ack", 32'(dbg_ack), 32'd0);
    chk("rst_in_dbg edge dbg_data", dbg_data, 32'd0);
    StallF  = 1'b0;
    dbg_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl2.size(); i++) step(100 + i, tbl2[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
